data_memory_sized: RTL and testbench
====================================

Name: data_memory_sized

Overview:
Parametrised successor to the flat word-only data memory in the RV32I core's data path. Adds byte, halfword and word loads/stores selected by funct3, with sign/zero extension on loads. Adds an alignment and illegal-encoding fault flag and configurable wait states behind a request/ready handshake. Sits between the core's load/store path and on-chip data storage.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
WAIT_STATES, 0, extra cycles inserted before each access completes; range 0..15.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
address  in  32  byte address; bits [1:0] select the lane; bits [log2(DEPTH_WORDS)+1:2] select the word; upper bits ignored (aliasing).
write_data  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
write_enable  in  1  store request.
read_enable  in  1  load request.
funct3  in  3  access size and extension, using RV32I load/store encodings.
read_data  out  32  extended load result.
ready  out  1  one-cycle completion pulse.
fault  out  1  valid with ready; access was misaligned or used an illegal funct3.

Behaviour:
- Reset (rst_n low at a clock edge):
  - read_data=0, ready=0, fault=0, state=IDLE, wait counter=0.
  - Memory array is not cleared; simulation initial contents are 0.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: if write_enable or read_enable is high, sample the request and load cnt=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else go to ACCESS.
  - WAIT: decrement cnt; go to ACCESS when cnt reaches 0.
  - ACCESS: commit the store or capture the load result into read_data, evaluate fault, then go to RESP.
  - RESP: ready=1 for exactly one cycle, then go to IDLE.
- Latency: the request is sampled at edge 0 and ready is high in the cycle after edge WAIT_STATES+1. That is WAIT_STATES+2 cycles; for WAIT_STATES=0, ready is high in the second cycle.
- Requester rules:
  - Hold address, data, funct3 and enables stable until ready.
  - Deassert the enables in the ready cycle, otherwise the block re-accepts in the next IDLE cycle.
  - Inputs are ignored outside IDLE.
- Both enables high: treated as a store; the read is ignored.
- Loads, funct3 encodings:
  - 000 LB and 100 LBU: byte lane address[1:0].
  - 001 LH and 101 LHU: halfword lane address[1].
  - 010 LW: full word.
  - LB and LH sign-extend; LBU and LHU zero-extend. Little-endian.
- Stores, funct3 encodings:
  - 000 SB, 001 SH, 010 SW.
  - Only the selected byte lanes are written; other bytes are preserved.
- Fault conditions:
  - Halfword access with address[0]=1.
  - Word access with address[1:0]!=0.
  - Loads with funct3 011, 110 or 111.
  - Stores with funct3 above 010.
- On fault: no memory write, read_data unchanged, and fault=1 together with ready. Otherwise fault=0 in the ready cycle. fault is 0 whenever ready is 0.
- read_data holds its last load value through stores and faults.
- Reset mid-operation: the pending access is abandoned. A store not yet in ACCESS is dropped; ready is not issued.
- Address wrap: word index taken modulo DEPTH_WORDS.

Decomposition:
- Shared package dmem_pkg:
  - funct3 encodings as constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum dmem_state_t.
  - Function computing a 4-bit byte-enable from funct3 and address[1:0].
- Sub-module dmem_lane_align (combinational):
  - Store path: write_data lane replication and byte-enable output.
  - Load path: lane extract and sign/zero extension.
  - Fault detection.
- FSM, counter and storage array live in the top module.

Test Plan:
- WAIT_STATES=0: SW 0xDEADBEEF @0x4, then LW @0x4 -> ready high in the 2nd cycle of each request; read_data=0xDEADBEEF, fault=0.
- SW 0xCAFEBABE @0x8; SB 0x80 @0x9 -> word 0xCAFE80BE. LB @0x9 -> 0xFFFFFF80; LBU @0x9 -> 0x00000080.
- SH 0x1234 @0xA on word 0xCAFE80BE -> LW @0x8 = 0x123480BE. LH @0xA -> 0x00001234; SH 0x8001 @0xA then LH @0xA -> 0xFFFF8001, LHU -> 0x00008001.
- LW @0x6, SH 0x5555 @0x3, load with funct3=011 -> each gives ready with fault=1; LW @0x4 still reads 0xDEADBEEF and read_data is unchanged across the faults.
- WAIT_STATES=3: LW @0x4 -> ready exactly 5 cycles after the request. Assert rst_n=0 during WAIT of a pending SW 0x11111111 @0x4 -> ready stays 0, word stays 0xDEADBEEF, state returns to IDLE.
- DEPTH_WORDS=1024: SW 0xA5A5A5A5 @0x1004 -> LW @0x4 = 0xA5A5A5A5. Both enables high with SW 0x0 @0x8 -> store performed.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: RV32I load/store funct3
// encodings, FSM state type and the byte-enable helper.
package dmem_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned F3_W_BITS = 3;
   localparam int unsigned CNT_W   = 4;

   localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
   localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
   localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
   localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
   localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } dmem_state_t;

   // Byte lanes touched by an access; funct3[1:0] is the size code.
   function automatic logic [3:0] byte_enable(input logic [F3_W_BITS-1:0] f3,
                                              input logic [1:0]           lane);
      logic [3:0] be;
      be = 4'b0000;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the sized data memory.
// Ports:
//   i_funct3   access size / extension code
//   i_lane     address[1:0] of the access
//   i_is_store 1 = store, 0 = load
//   i_wdata    right-aligned store data
//   i_rword    addressed storage word
//   o_wdata    store data replicated onto every lane
//   o_be       byte enables for the store
//   o_rdata    extracted and extended load result
//   o_fault    misaligned access or illegal funct3
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [F3_W_BITS-1:0] i_funct3,
   input  logic [1:0]           i_lane,
   input  logic                 i_is_store,
   input  logic [DATA_W-1:0]    i_wdata,
   input  logic [DATA_W-1:0]    i_rword,
   output logic [DATA_W-1:0]    o_wdata,
   output logic [3:0]           o_be,
   output logic [DATA_W-1:0]    o_rdata,
   output logic                 o_fault
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_legal;
   logic        w_misaligned;

   assign o_be = byte_enable(i_funct3, i_lane);

   // Replicate so the byte enables alone pick the destination lane.
   always_comb begin
      o_wdata = i_wdata;
      case (i_funct3[1:0])
         2'b00:   o_wdata = {4{i_wdata[7:0]}};
         2'b01:   o_wdata = {2{i_wdata[15:0]}};
         default: o_wdata = i_wdata;
      endcase
   end

   assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
   assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

   // Little-endian extract with sign or zero extension.
   always_comb begin
      o_rdata = i_rword;
      case (i_funct3)
         F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_rdata = {24'h000000, w_byte};
         F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
         F3_HU:   o_rdata = {16'h0000, w_half};
         default: o_rdata = i_rword;
      endcase
   end

   // Stores have no unsigned forms; loads accept 000,001,010,100,101.
   always_comb begin
      w_legal = 1'b0;
      if (i_is_store) begin
         w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
      end else begin
         w_legal = (i_funct3 == F3_B)  || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                   (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
      end
   end

   assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_lane[0]) ||
                         ((i_funct3[1:0] == 2'b10) && (i_lane != 2'b00));

   assign o_fault = !w_legal || w_misaligned;

endmodule

// File: rtl/data_memory_sized.sv
// Sized RV32I data memory with byte/halfword/word access, load extension,
// fault reporting and configurable wait states behind a request/ready
// handshake.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   address       byte address (word index wraps modulo DEPTH_WORDS)
//   write_data    right-aligned store data
//   write_enable  store request (wins if both enables are high)
//   read_enable   load request
//   funct3        RV32I load/store size code
//   read_data     last successful load result
//   ready         one-cycle completion pulse
//   fault         qualifies ready: misaligned or illegal encoding
module data_memory_sized
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_W-1:0]    address,
   input  logic [DATA_W-1:0]    write_data,
   input  logic                 write_enable,
   input  logic                 read_enable,
   input  logic [F3_W_BITS-1:0] funct3,
   output logic [DATA_W-1:0]    read_data,
   output logic                 ready,
   output logic                 fault
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   dmem_state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [AW-1:0]         r_idx, w_idx_nxt;
   logic [1:0]            r_lane, w_lane_nxt;
   logic [DATA_W-1:0]     r_wdata, w_wdata_nxt;
   logic                  r_we, w_we_nxt;
   logic [F3_W_BITS-1:0]  r_f3, w_f3_nxt;
   logic [DATA_W-1:0]     r_rdata, w_rdata_nxt;
   logic                  r_ready, w_ready_nxt;
   logic                  r_fault, w_fault_nxt;

   logic [DATA_W-1:0]     r_mem [DEPTH_WORDS];

   logic [DATA_W-1:0]     w_rword;
   logic [DATA_W-1:0]     w_wdata_rep;
   logic [3:0]            w_be;
   logic [DATA_W-1:0]     w_rdata_ext;
   logic                  w_fault;
   logic                  w_mem_we;
   logic                  w_unused_addr;

   // Upper address bits alias onto the array.
   assign w_unused_addr = ^address[DATA_W-1:AW+2];

   assign w_rword = r_mem[r_idx];

   dmem_lane_align u_align (
      .i_funct3   (r_f3),
      .i_lane     (r_lane),
      .i_is_store (r_we),
      .i_wdata    (r_wdata),
      .i_rword    (w_rword),
      .o_wdata    (w_wdata_rep),
      .o_be       (w_be),
      .o_rdata    (w_rdata_ext),
      .o_fault    (w_fault)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_lane  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_rdata <= '0;
         r_ready <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_lane  <= w_lane_nxt;
         r_wdata <= w_wdata_nxt;
         r_we    <= w_we_nxt;
         r_f3    <= w_f3_nxt;
         r_rdata <= w_rdata_nxt;
         r_ready <= w_ready_nxt;
         r_fault <= w_fault_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_lane_nxt  = r_lane;
      w_wdata_nxt = r_wdata;
      w_we_nxt    = r_we;
      w_f3_nxt    = r_f3;
      w_rdata_nxt = r_rdata;
      w_ready_nxt = 1'b0;
      w_fault_nxt = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (write_enable || read_enable) begin
               w_idx_nxt   = address[AW+1:2];
               w_lane_nxt  = address[1:0];
               w_wdata_nxt = write_data;
               w_we_nxt    = write_enable;
               w_f3_nxt    = funct3;
               w_cnt_nxt   = CNT_W'(WAIT_STATES);
               w_state_nxt = (WAIT_STATES != 0) ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) begin
               w_state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // ready rises as RESP is entered, so it is visible for the RESP cycle only.
            w_ready_nxt = 1'b1;
            w_fault_nxt = w_fault;
            if (!r_we && !w_fault) begin
               w_rdata_nxt = w_rdata_ext;
            end
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_mem_we = (r_state == S_ACCESS) && r_we && !w_fault;

   // Storage array; byte-lane write, contents survive reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[r_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
         end
      end
   end

   assign read_data = r_rdata;
   assign ready     = r_ready;
   assign fault     = r_fault;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: DUT A (1024 words, no wait states)
// and DUT B (16 words, 3 wait states) against a byte-array reference model.
module tb_data_memory_sized;

   typedef struct {
      logic [31:0] rd;
      logic        flt;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   logic        a_rst_n, b_rst_n;
   logic [31:0] a_addr, b_addr, a_wd, b_wd;
   logic        a_we, b_we, a_re, b_re;
   logic [2:0]  a_f3, b_f3;
   logic [31:0] a_read_data, b_read_data;
   logic        a_ready, b_ready, a_fault, b_fault;

   logic [7:0]  mA [4096];
   logic [7:0]  mB [64];
   logic [31:0] rdA, rdB;
   exp_t        qa[$];
   exp_t        qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_memory_sized #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .address(a_addr), .write_data(a_wd),
      .write_enable(a_we), .read_enable(a_re), .funct3(a_f3),
      .read_data(a_read_data), .ready(a_ready), .fault(a_fault));

   data_memory_sized #(.DEPTH_WORDS(16), .WAIT_STATES(3)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .address(b_addr), .write_data(b_wd),
      .write_enable(b_we), .read_enable(b_re), .funct3(b_f3),
      .read_data(b_read_data), .ready(b_ready), .fault(b_fault));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Fault rule from the ISA view: legal encodings, then natural alignment.
   function automatic bit mfault(input bit st, input logic [2:0] f3, input logic [1:0] lo);
      bit legal;
      int sz;
      legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
      sz = 1 << f3[1:0];
      return (int'(lo) % sz) != 0;
   endfunction

   // Reference: memory as a flat byte array, little-endian, wrapping.
   task automatic model(input bit sel, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt);
      int unsigned nb;
      int          sz;
      int unsigned ba;
      logic [31:0] v;
      nb  = sel ? 64 : 4096;
      sz  = 1 << f3[1:0];
      flt = mfault(st, f3, addr[1:0]);
      rd  = sel ? rdB : rdA;
      if (!flt) begin
         v = 32'd0;
         for (int k = 0; k < sz; k++) begin
            ba = (addr + 32'(k)) % nb;
            if (st) begin
               if (sel) mB[ba] = wd[8*k +: 8];
               else     mA[ba] = wd[8*k +: 8];
            end else begin
               v = v | (32'(sel ? mB[ba] : mA[ba]) << (8*k));
            end
         end
         if (!st) begin
            if (!f3[2] && sz < 4 && v[8*sz-1])
               v = v | ~((32'd1 << (8*sz)) - 32'd1);
            rd = v;
            if (sel) rdB = v;
            else     rdA = v;
         end
      end
   endtask

   task automatic drive(input bit sel, input bit we, input bit re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (sel) begin
         b_we = we; b_re = re; b_f3 = f3; b_addr = addr; b_wd = wd;
      end else begin
         a_we = we; a_re = re; a_f3 = f3; a_addr = addr; a_wd = wd;
      end
   endtask

   // Issue one request from an IDLE cycle and hold it until ready.
   task automatic issue(input bit sel, input bit we, input bit re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      exp_t        e;
      logic [31:0] rd;
      logic        flt;
      int          n;
      model(sel, we, f3, addr, wd, rd, flt);
      e.rd  = rd;
      e.flt = flt;
      e.due = cyc + (sel ? 3 : 0) + 2;
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
      drive(sel, we, re, f3, addr, wd);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sel ? b_ready : a_ready) && n < 50);
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL ready_timeout dut=%0d got no ready want ready", sel);
         if (sel && qb.size() > 0) void'(qb.pop_front());
         if (!sel && qa.size() > 0) void'(qa.pop_front());
      end
      drive(sel, 1'b0, 1'b0, f3, addr, wd);
      @(negedge clk);
   endtask

   task automatic score(input string nm, input exp_t e, input logic [31:0] rd, input logic flt);
      chk({nm, "_rdata"}, rd, e.rd);
      chk({nm, "_fault"}, 32'(flt), 32'(e.flt));
      chk({nm, "_latency"}, 32'(cyc), 32'(e.due));
   endtask

   // Monitors: pop one expectation per ready pulse.
   always @(negedge clk) begin
      exp_t e;
      if (a_rst_n && a_ready) begin
         if (qa.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected_ready: got ready=1 want 0 (cyc %0d)", cyc);
         end else begin
            e = qa.pop_front();
            score("a", e, a_read_data, a_fault);
         end
      end else if (a_rst_n && a_fault) begin
         total++; bad++;
         $display("FAIL a_fault_idle: got fault=1 want 0 (cyc %0d)", cyc);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (b_rst_n && b_ready) begin
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_ready: got ready=1 want 0 (cyc %0d)", cyc);
         end else begin
            e = qb.pop_front();
            score("b", e, b_read_data, b_fault);
         end
      end else if (b_rst_n && b_fault) begin
         total++; bad++;
         $display("FAIL b_fault_idle: got fault=1 want 0 (cyc %0d)", cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd_hold;
      for (int i = 0; i < 4096; i++) mA[i] = 8'h00;
      for (int i = 0; i < 64; i++)   mB[i] = 8'h00;
      rdA = 32'd0; rdB = 32'd0;
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_a_rdata", a_read_data, 32'h0);
      chk("rst_a_ready", 32'(a_ready), 32'h0);
      chk("rst_a_fault", 32'(a_fault), 32'h0);
      chk("rst_b_rdata", b_read_data, 32'h0);
      chk("rst_b_ready", 32'(b_ready), 32'h0);
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      @(negedge clk);

      // Directed sequence, no wait states.
      issue(0, 1, 0, 3'b010, 32'h4, 32'hDEADBEEF);
      issue(0, 0, 1, 3'b010, 32'h4, 32'h0);
      chk("lw_dead", a_read_data, 32'hDEADBEEF);
      issue(0, 1, 0, 3'b010, 32'h8, 32'hCAFEBABE);
      issue(0, 1, 0, 3'b000, 32'h9, 32'h00000080);
      issue(0, 0, 1, 3'b000, 32'h9, 32'h0);
      chk("lb_sext", a_read_data, 32'hFFFFFF80);
      issue(0, 0, 1, 3'b100, 32'h9, 32'h0);
      chk("lbu_zext", a_read_data, 32'h00000080);
      issue(0, 1, 0, 3'b001, 32'hA, 32'h00001234);
      issue(0, 0, 1, 3'b010, 32'h8, 32'h0);
      chk("lw_after_sh", a_read_data, 32'h123480BE);
      issue(0, 0, 1, 3'b001, 32'hA, 32'h0);
      chk("lh_pos", a_read_data, 32'h00001234);
      issue(0, 1, 0, 3'b001, 32'hA, 32'h00008001);
      issue(0, 0, 1, 3'b001, 32'hA, 32'h0);
      chk("lh_neg", a_read_data, 32'hFFFF8001);
      issue(0, 0, 1, 3'b101, 32'hA, 32'h0);
      chk("lhu", a_read_data, 32'h00008001);
      rd_hold = a_read_data;
      issue(0, 0, 1, 3'b010, 32'h6, 32'h0);
      issue(0, 1, 0, 3'b001, 32'h3, 32'h5555);
      issue(0, 0, 1, 3'b011, 32'h0, 32'h0);
      chk("rdata_held_faults", a_read_data, rd_hold);
      issue(0, 0, 1, 3'b010, 32'h4, 32'h0);
      chk("lw_after_faults", a_read_data, 32'hDEADBEEF);
      issue(0, 1, 0, 3'b010, 32'h1004, 32'hA5A5A5A5);
      issue(0, 0, 1, 3'b010, 32'h4, 32'h0);
      chk("alias_wrap", a_read_data, 32'hA5A5A5A5);
      issue(0, 1, 1, 3'b010, 32'h8, 32'h0);
      issue(0, 0, 1, 3'b010, 32'h8, 32'h0);
      chk("both_en_store", a_read_data, 32'h0);

      // DUT B: fill, latency and mid-operation reset.
      for (int w = 0; w < 16; w++) issue(1, 1, 0, 3'b010, 32'(w * 4), $urandom);
      issue(1, 1, 0, 3'b010, 32'h4, 32'hDEADBEEF);
      issue(1, 0, 1, 3'b010, 32'h4, 32'h0);
      chk("b_lw_dead", b_read_data, 32'hDEADBEEF);
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h4, 32'h11111111);
      repeat (2) @(negedge clk);
      b_rst_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h4, 32'h0);
      @(negedge clk);
      b_rst_n = 1'b1;
      rdB = 32'd0;
      chk("b_rst_mid_rdata", b_read_data, 32'h0);
      repeat (8) @(negedge clk);
      chk("b_rst_mid_ready", 32'(b_ready), 32'h0);
      issue(1, 0, 1, 3'b010, 32'h4, 32'h0);
      chk("b_store_dropped", b_read_data, 32'hDEADBEEF);

      // Randomized traffic over a 16-word window with aliasing upper bits.
      for (int w = 0; w < 16; w++) issue(0, 1, 0, 3'b010, 32'(w * 4), $urandom);
      for (int i = 0; i < 300; i++) begin
         bit          sel, we, re;
         logic [2:0]  f3;
         sel = (i % 3) == 2;
         we  = 1'($urandom_range(0, 1));
         re  = we ? 1'($urandom_range(0, 1)) : 1'b1;
         f3  = 3'($urandom_range(0, 7));
         issue(sel, we, re, f3, $urandom & 32'hFFFF_F03F, $urandom);
      end

      repeat (10) @(negedge clk);
      chk("qa_drained", 32'(qa.size()), 32'd0);
      chk("qb_drained", 32'(qb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
